// File: rtl/multi_ch_event_sync_if.sv
// Bundle of per-channel event lines, pending-event handshake and status shared
// between the event synchroniser (slave) and its consumer/driver (master).
interface multi_ch_event_sync_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 3
);
   logic [NUM_CH-1:0]       async_in;
   logic [NUM_CH-1:0]       evt_pulse;
   logic [NUM_CH-1:0]       evt_valid;
   logic [NUM_CH-1:0]       evt_ack;
   logic [NUM_CH*CNT_W-1:0] evt_count;
   logic [NUM_CH-1:0]       ovf;
   logic [NUM_CH-1:0]       ovf_clr;
   logic                    init_done;

   modport master (
      output async_in, evt_ack, ovf_clr,
      input  evt_pulse, evt_valid, evt_count, ovf, init_done
   );

   modport slave (
      input  async_in, evt_ack, ovf_clr,
      output evt_pulse, evt_valid, evt_count, ovf, init_done
   );
endinterface

// File: rtl/multi_ch_event_sync.sv
// Multi-channel event synchroniser: per-channel sync chain, toggle/rising detect,
// saturating pending counter drained by valid/ack, sticky overflow flag.
module multi_ch_event_sync #(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 3,
   parameter int EDGE_MODE   = 0
) (
   input logic                  clk,
   input logic                  rst_n,
   multi_ch_event_sync_if.slave bus
);
   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

   localparam logic [2:0]       INIT_LAST = 3'(SYNC_STAGES);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e                  state_q, state_d;
   logic [2:0]              init_cnt_q, init_cnt_d;
   logic                    arm_s;
   logic [NUM_CH-1:0]       sync_q [SYNC_STAGES];
   logic [NUM_CH-1:0]       hist_q;
   logic [NUM_CH-1:0]       det_s;
   logic [NUM_CH-1:0]       valid_s;
   logic [NUM_CH-1:0]       ack_s;
   logic [NUM_CH-1:0]       pulse_q, pulse_d;
   logic [NUM_CH-1:0]       ovf_q, ovf_d;
   logic [CNT_W-1:0]        cnt_q [NUM_CH];
   logic [CNT_W-1:0]        cnt_d [NUM_CH];
   logic [NUM_CH*CNT_W-1:0] count_s;

   // Arming state machine: state and INIT-window counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         init_cnt_q <= 3'd0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // Arming state machine: next state, leaving INIT once the chains have flushed
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q + 3'd1;
            if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
            else                         state_d = ST_INIT;
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   // Arming state machine: outputs
   always_comb begin
      if (state_q == ST_RUN) arm_s = 1'b1;
      else                   arm_s = 1'b0;
   end

   // Synchroniser chains and the history flop behind the last stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= {NUM_CH{1'b0}};
         hist_q <= {NUM_CH{1'b0}};
      end else begin
         sync_q[0] <= bus.async_in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Event detection, masked until the chains hold real input samples
   always_comb begin
      if (EDGE_MODE != 0) det_s = sync_q[SYNC_STAGES-1] & ~hist_q & {NUM_CH{arm_s}};
      else                det_s = (sync_q[SYNC_STAGES-1] ^ hist_q) & {NUM_CH{arm_s}};
   end

   // Pending counter update; a simultaneous event and ack cancel out
   always_comb begin
      valid_s = {NUM_CH{1'b0}};
      ack_s   = {NUM_CH{1'b0}};
      pulse_d = det_s;
      ovf_d   = ovf_q & ~bus.ovf_clr;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]   = cnt_q[i];
         valid_s[i] = (cnt_q[i] != {CNT_W{1'b0}});
         ack_s[i]   = bus.evt_ack[i] & valid_s[i];
         case ({det_s[i], ack_s[i]})
            2'b10: begin
               if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
               else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
            2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   // Pulse, counter and overflow registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_q <= {NUM_CH{1'b0}};
         ovf_q   <= {NUM_CH{1'b0}};
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= {CNT_W{1'b0}};
      end else begin
         pulse_q <= pulse_d;
         ovf_q   <= ovf_d;
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Pack per-channel counts onto the flat count bus
   always_comb begin
      count_s = {(NUM_CH*CNT_W){1'b0}};
      for (int i = 0; i < NUM_CH; i++) count_s[i*CNT_W +: CNT_W] = cnt_q[i];
   end

   assign bus.evt_pulse = pulse_q;
   assign bus.evt_valid = valid_s;
   assign bus.evt_count = count_s;
   assign bus.ovf       = ovf_q;
   assign bus.init_done = arm_s;
endmodule
